// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects load data or ALU result for write-back,
// drives the register-file write port and WB->EX forwarding, and keeps retirement counters.
package mem_wb_pkg;
   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
   } control_type;
endpackage

module mem_wb_stage
   import mem_wb_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              valid_in,
   input  logic              stall,
   input  logic              flush,
   input  logic [31:0]       alu_data_in,
   input  logic [31:0]       memory_data_in,
   input  control_type       control_in,
   input  logic [4:0]        rd_in,
   output logic              valid_out,
   output logic              reg_write_en,
   output logic [4:0]        reg_write_id,
   output logic [31:0]       reg_write_data,
   output logic              fwd_valid,
   output logic [4:0]        fwd_rd,
   output logic [31:0]       fwd_data,
   output logic [63:0]       instret,
   output logic [CNT_W-1:0]  load_count,
   output logic [CNT_W-1:0]  store_count
);

   logic              cap;
   logic [31:0]       wb_data_p0;
   logic              we_p0;

   logic              vld_p1;
   logic              we_p1;
   logic [4:0]        id_p1;
   logic [31:0]       data_p1;
   logic [63:0]       instret_q;
   logic [CNT_W-1:0]  load_cnt_q;
   logic [CNT_W-1:0]  store_cnt_q;

   // ---- MEM side: capture qualification and write-back select ----
   assign cap        = valid_in & ~stall & ~flush;
   assign wb_data_p0 = control_in.mem_read ? memory_data_in : alu_data_in;
   // x0 is hardwired to zero, so a write to it is never enabled
   assign we_p0      = valid_in & control_in.reg_write & (rd_in != 5'd0);

   // ---- WB register: flush beats stall; flush leaves id/data untouched ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1  <= 1'b0;
         we_p1   <= 1'b0;
         id_p1   <= 5'd0;
         data_p1 <= 32'd0;
      end else if (flush) begin
         vld_p1  <= 1'b0;
         we_p1   <= 1'b0;
      end else if (!stall) begin
         vld_p1  <= valid_in;
         we_p1   <= we_p0;
         id_p1   <= rd_in;
         data_p1 <= wb_data_p0;
      end
   end

   // ---- Retirement counters, free-running modulo their width ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instret_q   <= 64'd0;
         load_cnt_q  <= '0;
         store_cnt_q <= '0;
      end else if (cap) begin
         instret_q   <= instret_q + 64'd1;
         load_cnt_q  <= load_cnt_q + CNT_W'(control_in.mem_read);
         store_cnt_q <= store_cnt_q + CNT_W'(control_in.mem_write);
      end
   end

   assign valid_out      = vld_p1;
   assign reg_write_en   = we_p1;
   assign reg_write_id   = id_p1;
   assign reg_write_data = data_p1;
   assign fwd_valid      = we_p1;
   assign fwd_rd         = id_p1;
   assign fwd_data       = data_p1;
   assign instret        = instret_q;
   assign load_count     = load_cnt_q;
   assign store_count    = store_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a 4-bit counter width so wrap-around is reachable.
module tb_mem_wb_stage;
   import mem_wb_pkg::*;

   localparam int CNT_W = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              valid_in, stall, flush;
   logic [31:0]       alu_data_in, memory_data_in;
   control_type       control_in;
   logic [4:0]        rd_in;
   logic              valid_out, reg_write_en, fwd_valid;
   logic [4:0]        reg_write_id, fwd_rd;
   logic [31:0]       reg_write_data, fwd_data;
   logic [63:0]       instret;
   logic [CNT_W-1:0]  load_count, store_count;

   int n_tests = 0;
   int n_fail  = 0;

   mem_wb_stage #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .stall(stall), .flush(flush),
      .alu_data_in(alu_data_in), .memory_data_in(memory_data_in), .control_in(control_in),
      .rd_in(rd_in), .valid_out(valid_out), .reg_write_en(reg_write_en),
      .reg_write_id(reg_write_id), .reg_write_data(reg_write_data), .fwd_valid(fwd_valid),
      .fwd_rd(fwd_rd), .fwd_data(fwd_data), .instret(instret), .load_count(load_count),
      .store_count(store_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem);
      valid_in             = v;
      control_in.reg_write = rw;
      control_in.mem_read  = mr;
      control_in.mem_write = mw;
      rd_in                = rd;
      alu_data_in          = alu;
      memory_data_in       = mem;
   endtask

   task automatic test_reset();
      stall = 0; flush = 0;
      drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
      reset_n = 0;
      cyc(); cyc();
      reset_n = 1;
      cyc();
      n_tests++;
      if ({valid_out, reg_write_en, reg_write_id, reg_write_data} !== 39'd0) begin
         n_fail++; $display("FAIL reset_wb: act=%h req=0", {valid_out, reg_write_en, reg_write_id, reg_write_data});
      end
      n_tests++;
      if ({fwd_valid, fwd_rd, fwd_data, instret, load_count, store_count} !== 110'd0) begin
         n_fail++; $display("FAIL reset_fwd_cnt: instret=%0d loads=%0d stores=%0d req=0", instret, load_count, store_count);
      end
      // capture a load, then assert reset mid-cycle
      drive(1, 1, 1, 0, 5'd6, 32'h10, 32'h1234_5678);
      cyc();
      drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
      n_tests++;
      if (valid_out !== 1'b1 || instret !== 64'd1) begin
         n_fail++; $display("FAIL pre_reset_capture: valid=%b instret=%0d req valid=1 instret=1", valid_out, instret);
      end
      #2 reset_n = 0;
      #1;
      n_tests++;
      if ({valid_out, reg_write_en, reg_write_id, reg_write_data, fwd_valid, instret, load_count} !== 108'd0) begin
         n_fail++; $display("FAIL async_reset: valid=%b we=%b id=%0d data=%h instret=%0d req all 0", valid_out, reg_write_en, reg_write_id, reg_write_data, instret);
      end
      cyc();
      reset_n = 1;
      drive(1, 1, 1, 0, 5'd2, 32'h20, 32'h0000_00AB);
      cyc();
      drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
      n_tests++;
      if (instret !== 64'd1 || load_count !== 4'd1 || reg_write_data !== 32'h0000_00AB) begin
         n_fail++; $display("FAIL post_reset_load: instret=%0d loads=%0d data=%h req 1 1 000000ab", instret, load_count, reg_write_data);
      end
   endtask

   task automatic test_select();
      drive(1, 1, 1, 0, 5'd5, 32'h0000_1003, 32'hFFFF_FF80);
      cyc();
      n_tests++;
      if ({reg_write_en, reg_write_id, reg_write_data} !== {1'b1, 5'd5, 32'hFFFF_FF80}) begin
         n_fail++; $display("FAIL load_select: we=%b id=%0d data=%h req 1 5 ffffff80", reg_write_en, reg_write_id, reg_write_data);
      end
      n_tests++;
      if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 5'd5, 32'hFFFF_FF80}) begin
         n_fail++; $display("FAIL load_fwd: v=%b rd=%0d data=%h req 1 5 ffffff80", fwd_valid, fwd_rd, fwd_data);
      end
      drive(1, 1, 0, 0, 5'd5, 32'h0000_1003, 32'hFFFF_FF80);
      cyc();
      n_tests++;
      if ({reg_write_en, reg_write_data, instret, load_count} !== {1'b1, 32'h0000_1003, 64'd3, 4'd2}) begin
         n_fail++; $display("FAIL alu_select: we=%b data=%h instret=%0d loads=%0d req 1 00001003 3 2", reg_write_en, reg_write_data, instret, load_count);
      end
   endtask

   task automatic test_x0_store();
      drive(1, 1, 1, 0, 5'd0, 32'h1, 32'h2);
      cyc();
      n_tests++;
      if ({valid_out, reg_write_en, fwd_valid, instret} !== {3'b100, 64'd4}) begin
         n_fail++; $display("FAIL x0_load: valid=%b we=%b fwd=%b instret=%0d req 1 0 0 4", valid_out, reg_write_en, fwd_valid, instret);
      end
      drive(1, 0, 0, 1, 5'd7, 32'h0000_2000, 32'h0);
      cyc();
      n_tests++;
      if ({valid_out, reg_write_en, store_count, load_count, instret} !== {2'b10, 4'd1, 4'd3, 64'd5}) begin
         n_fail++; $display("FAIL store: valid=%b we=%b stores=%0d loads=%0d instret=%0d req 1 0 1 3 5", valid_out, reg_write_en, store_count, load_count, instret);
      end
   endtask

   task automatic test_stall();
      drive(1, 1, 0, 0, 5'd3, 32'hAAAA_0001, 32'h0);
      cyc();
      drive(1, 1, 0, 0, 5'd4, 32'hBBBB_0002, 32'h0);
      stall = 1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         n_tests++;
         if ({valid_out, reg_write_en, reg_write_id, reg_write_data, instret} !== {2'b11, 5'd3, 32'hAAAA_0001, 64'd6}) begin
            n_fail++; $display("FAIL stall_hold[%0d]: id=%0d data=%h instret=%0d req 3 aaaa0001 6", k, reg_write_id, reg_write_data, instret);
         end
      end
      stall = 0;
      cyc();
      n_tests++;
      if ({reg_write_id, reg_write_data, instret} !== {5'd4, 32'hBBBB_0002, 64'd7}) begin
         n_fail++; $display("FAIL stall_release: id=%0d data=%h instret=%0d req 4 bbbb0002 7", reg_write_id, reg_write_data, instret);
      end
   endtask

   task automatic test_flush_bubble();
      drive(1, 1, 1, 1, 5'd9, 32'hCCCC_0003, 32'hDDDD_0004);
      flush = 1; stall = 1;
      cyc();
      n_tests++;
      if ({valid_out, reg_write_en, fwd_valid, instret, load_count, store_count} !== {3'b000, 64'd7, 4'd3, 4'd1}) begin
         n_fail++; $display("FAIL flush_stall: valid=%b we=%b instret=%0d loads=%0d stores=%0d req 0 0 7 3 1", valid_out, reg_write_en, instret, load_count, store_count);
      end
      n_tests++;
      if ({reg_write_id, reg_write_data} !== {5'd4, 32'hBBBB_0002}) begin
         n_fail++; $display("FAIL flush_hold_data: id=%0d data=%h req 4 bbbb0002", reg_write_id, reg_write_data);
      end
      stall = 0;
      cyc();
      n_tests++;
      if ({valid_out, reg_write_en, instret} !== {2'b00, 64'd7}) begin
         n_fail++; $display("FAIL flush_only: valid=%b we=%b instret=%0d req 0 0 7", valid_out, reg_write_en, instret);
      end
      flush = 0;
      drive(0, 1, 1, 0, 5'd8, 32'h5, 32'h6);
      cyc();
      n_tests++;
      if ({valid_out, reg_write_en, instret, load_count} !== {2'b00, 64'd7, 4'd3}) begin
         n_fail++; $display("FAIL bubble: valid=%b we=%b instret=%0d loads=%0d req 0 0 7 3", valid_out, reg_write_en, instret, load_count);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 3; i++) begin
         drive(1, 1, 0, 0, 5'(i), 32'h100 + 32'(i), 32'h0);
         cyc();
         n_tests++;
         if ({reg_write_en, reg_write_id, reg_write_data, instret} !== {1'b1, 5'(i), 32'h100 + 32'(i), 64'(7 + i)}) begin
            n_fail++; $display("FAIL back_to_back[%0d]: id=%0d data=%h instret=%0d req %0d %h %0d", i, reg_write_id, reg_write_data, instret, i, 32'h100 + 32'(i), 7 + i);
         end
      end
   endtask

   task automatic test_wrap();
      drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
      reset_n = 0;
      cyc();
      reset_n = 1;
      drive(1, 1, 1, 0, 5'd10, 32'h0, 32'h0000_0042);
      repeat (15) cyc();
      n_tests++;
      if (load_count !== 4'hF || instret !== 64'd15) begin
         n_fail++; $display("FAIL wrap_pre: loads=%h instret=%0d req f 15", load_count, instret);
      end
      cyc();
      drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
      n_tests++;
      if (load_count !== 4'h0 || instret !== 64'd16 || store_count !== 4'h0) begin
         n_fail++; $display("FAIL wrap: loads=%h instret=%0d stores=%h req 0 16 0", load_count, instret, store_count);
      end
   endtask

   initial begin
      test_reset();
      test_select();
      test_x0_store();
      test_stall();
      test_flush_bubble();
      test_back_to_back();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register and write-back select between `mem_stage` and the register file. Captures the MEM-stage result each cycle and chooses load data or ALU result as the write-back value. Drives the register-file write port and the WB→EX forwarding path. Maintains retirement, load and store counters for debug and verification.

## Interface

Parameters
- `CNT_W`, default 32: width of `load_count` and `store_count`.

Ports
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `valid_in`  in  1  MEM stage holds a real instruction this cycle.
- `stall`  in  1  hold every WB register; no capture.
- `flush`  in  1  kill the instruction being captured.
- `alu_data_in`  in  32  ALU result / address from `mem_stage.alu_data_out`.
- `memory_data_in`  in  32  extended load data from `mem_stage.memory_data_out`.
- `control_in`  in  `control_type`  from `mem_stage.control_out`. Fields used: `reg_write`, `mem_read`, `mem_write`.
- `rd_in`  in  5  destination register index.
- `valid_out`  out  1  WB register holds a live instruction.
- `reg_write_en`  out  1  register-file write enable.
- `reg_write_id`  out  5  register-file write index.
- `reg_write_data`  out  32  register-file write data.
- `fwd_valid`  out  1  forwarding entry valid; equals `reg_write_en`.
- `fwd_rd`  out  5  forwarding register index; equals `reg_write_id`.
- `fwd_data`  out  32  forwarding data; equals `reg_write_data`.
- `instret`  out  64  retired-instruction count.
- `load_count`  out  `CNT_W`  retired loads.
- `store_count`  out  `CNT_W`  retired stores.

## Operation

- Capture: `cap = valid_in & ~stall & ~flush`.
- Write-back data select, computed on the MEM side before the register:
  - `wb_data = control_in.mem_read ? memory_data_in : alu_data_in`.
- Register update, evaluated in priority order:
  - `flush` (with or without `stall`): `valid_q←0`, `we_q←0`. Data and id registers hold their values. Counters unchanged.
  - else `stall`: all registers and counters hold.
  - else: `valid_q←valid_in`, `id_q←rd_in`, `data_q←wb_data`, `we_q←valid_in & control_in.reg_write & (rd_in≠0)`.
- x0 protection: `rd_in==0` never raises `reg_write_en`, including for loads.
- Stores (`mem_write=1`, `reg_write=0`) retire with `valid_out=1` and `reg_write_en=0`.
- Counters update only on `cap`, using the captured `control_in`:
  - `instret += 1`.
  - `load_count += mem_read`.
  - `store_count += mem_write`.
  - All counters wrap modulo 2^width with no saturation. `instret` is 64-bit and also wraps.
- Outputs are the registered values only. No combinational path runs from any input to any output.

## Timing

- Latency: inputs present at edge N appear on the outputs after edge N.
- `reg_write_data` is stable for the whole cycle so the register file can write on the next edge. The register file handles same-cycle read-during-write itself; this block does not bypass.
- Reset (asynchronous assert, removal synchronous to `clk`). All of the following clear to 0:
  - `valid_out`, `reg_write_en`, `reg_write_id`, `reg_write_data`.
  - All `fwd_*` outputs.
  - `instret`, `load_count`, `store_count`.
- Reset mid-stream: a captured instruction is dropped and its counter increments are lost. The first capture after release counts from 0.
- `stall` held for K cycles: outputs stay constant for K cycles. Exactly one retirement is counted, when `stall` drops and `cap` is true.
- `flush` and `stall` together: flush wins. `valid_out` is 0 on the next cycle.
- `valid_in=0` with `stall=0`: bubble, so `valid_out=0`, `reg_write_en=0`, and counters hold.
- Back-to-back captures: one retirement per cycle. Counters increment every cycle.

## Test plan

- Reset: assert `reset_n=0` mid-cycle with `valid_out=1` → all outputs are 0 immediately with no clock edge. After release, the first captured load gives `instret=1`, `load_count=1`.
- Load vs ALU select:
  - Load: `mem_read=1`, `reg_write=1`, `rd_in=5`, `memory_data_in=32'hFFFF_FF80`, `alu_data_in=32'h0000_1003` → next cycle `reg_write_en=1`, `id=5`, `data=32'hFFFF_FF80`.
  - ALU op: same stimulus with `mem_read=0` → `data=32'h0000_1003`.
- x0 and store:
  - `rd_in=0`, `reg_write=1` → `valid_out=1`, `reg_write_en=0`, `instret` +1.
  - Store: `mem_write=1`, `reg_write=0` → `reg_write_en=0`, `store_count` +1.
- Stall: capture instruction A, then assert `stall` for 3 cycles while presenting B → A held on outputs for 3 cycles and `instret` +1 only. On release, B appears one cycle later and `instret` +1.
- Flush priority: `flush=1`, `stall=1`, `valid_in=1`, `reg_write=1` → next cycle `valid_out=0`, `reg_write_en=0`, counters unchanged.
- Wrap: preload with `CNT_W=4` and 15 loads retired → `load_count=4'hF`. One more load → `4'h0`. `instret` continues counting, =16.
